// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: opcodes, control-field widths,
// the bubble constant and the main control decoder.
package mips_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned NREGS  = 32;
    localparam int unsigned RIDX_W = 5;
    localparam int unsigned OPC_W  = 6;
    localparam int unsigned IMM_W  = 16;
    localparam int unsigned WB_W   = 2;
    localparam int unsigned M_W    = 3;
    localparam int unsigned EX_W   = 4;

    localparam logic [OPC_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OPC_W-1:0] OP_LW    = 6'h23;
    localparam logic [OPC_W-1:0] OP_SW    = 6'h2B;
    localparam logic [OPC_W-1:0] OP_BEQ   = 6'h04;

    // wb = {RegWrite, MemtoReg}; m = {Branch, MemRead, MemWrite};
    // ex = {RegDst, ALUOp[1:0], ALUSrc}
    typedef struct packed {
        logic [WB_W-1:0] wb;
        logic [M_W-1:0]  m;
        logic [EX_W-1:0] ex;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

    // Opcode to control fields; unknown opcodes decode to a bubble.
    function automatic ctrl_t decode_ctrl(input logic [OPC_W-1:0] op);
        ctrl_t c;
        c = CTRL_BUBBLE;
        case (op)
            OP_RTYPE: c = '{wb: 2'b10, m: 3'b000, ex: 4'b1100};
            OP_LW:    c = '{wb: 2'b11, m: 3'b010, ex: 4'b0001};
            OP_SW:    c = '{wb: 2'b00, m: 3'b001, ex: 4'b0001};
            OP_BEQ:   c = '{wb: 2'b00, m: 3'b100, ex: 4'b0010};
            default:  c = CTRL_BUBBLE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/i_decode_regfile.sv
// 32x32 register file with $0 hardwired to zero and write-through bypass.
// Ports:
//   clk, rst          clock, synchronous active-high reset (clears all regs)
//   we, wr_idx, wr_data   writeback port, stored at the rising edge
//   rd_idx1/rd_data1, rd_idx2/rd_data2   combinational read ports
module regfile
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [RIDX_W-1:0] wr_idx,
    input  logic [XLEN-1:0]   wr_data,
    input  logic [RIDX_W-1:0] rd_idx1,
    input  logic [RIDX_W-1:0] rd_idx2,
    output logic [XLEN-1:0]   rd_data1,
    output logic [XLEN-1:0]   rd_data2
);

    // $0 has no storage; index 0 always reads as zero.
    logic [XLEN-1:0] mem [1:NREGS-1];
    logic            wr_ok;

    assign wr_ok = we && (wr_idx != '0);

    // Storage update
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 1; i < NREGS; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_ok) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // Read with same-cycle writeback bypass
    function automatic logic [XLEN-1:0] read_port(input logic [RIDX_W-1:0] idx);
        logic [XLEN-1:0] v;
        if (idx == '0) begin
            v = '0;
        end else if (wr_ok && (idx == wr_idx)) begin
            v = wr_data;
        end else begin
            v = mem[idx];
        end
        return v;
    endfunction

    always_comb begin
        rd_data1 = read_port(rd_idx1);
        rd_data2 = read_port(rd_idx2);
    end

endmodule

// File: rtl/i_decode.sv
// Instruction-decode stage: control decode, register read, sign extension
// and the ID/EX pipeline latch.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   IF_ID_instr, IF_ID_npc           instruction and PC+4 from IF/ID
//   ID_flush                         latch a bubble instead of the decoded controls
//   MEM_WB_regwrite/rd/writedata     writeback into the register file
//   ID_EX_*                          registered outputs to the execute stage
module i_decode
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [XLEN-1:0]   IF_ID_instr,
    input  logic [XLEN-1:0]   IF_ID_npc,
    input  logic              ID_flush,
    input  logic              MEM_WB_regwrite,
    input  logic [RIDX_W-1:0] MEM_WB_rd,
    input  logic [XLEN-1:0]   MEM_WB_writedata,
    output logic [WB_W-1:0]   ID_EX_wb,
    output logic [M_W-1:0]    ID_EX_m,
    output logic [EX_W-1:0]   ID_EX_ex,
    output logic [XLEN-1:0]   ID_EX_npc,
    output logic [XLEN-1:0]   ID_EX_readdat1,
    output logic [XLEN-1:0]   ID_EX_readdat2,
    output logic [XLEN-1:0]   ID_EX_sign_ext,
    output logic [RIDX_W-1:0] ID_EX_instr_2016,
    output logic [RIDX_W-1:0] ID_EX_instr_1511
);

    logic [RIDX_W-1:0] rs;
    logic [RIDX_W-1:0] rt;
    logic [RIDX_W-1:0] rd;
    logic [XLEN-1:0]   rdata1;
    logic [XLEN-1:0]   rdata2;
    logic [XLEN-1:0]   sign_ext_c;
    ctrl_t             ctrl_c;

    assign rs = IF_ID_instr[25:21];
    assign rt = IF_ID_instr[20:16];
    assign rd = IF_ID_instr[15:11];

    regfile u_regfile (
        .clk      (clk),
        .rst      (rst),
        .we       (MEM_WB_regwrite),
        .wr_idx   (MEM_WB_rd),
        .wr_data  (MEM_WB_writedata),
        .rd_idx1  (rs),
        .rd_idx2  (rt),
        .rd_data1 (rdata1),
        .rd_data2 (rdata2)
    );

    // Control decode; flush forces a bubble
    always_comb begin
        ctrl_c = decode_ctrl(IF_ID_instr[31:26]);
        if (ID_flush) begin
            ctrl_c = CTRL_BUBBLE;
        end
    end

    assign sign_ext_c = {{(XLEN-IMM_W){IF_ID_instr[IMM_W-1]}}, IF_ID_instr[IMM_W-1:0]};

    // ID/EX latch, updated every cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            ID_EX_wb         <= '0;
            ID_EX_m          <= '0;
            ID_EX_ex         <= '0;
            ID_EX_npc        <= '0;
            ID_EX_readdat1   <= '0;
            ID_EX_readdat2   <= '0;
            ID_EX_sign_ext   <= '0;
            ID_EX_instr_2016 <= '0;
            ID_EX_instr_1511 <= '0;
        end else begin
            ID_EX_wb         <= ctrl_c.wb;
            ID_EX_m          <= ctrl_c.m;
            ID_EX_ex         <= ctrl_c.ex;
            ID_EX_npc        <= IF_ID_npc;
            ID_EX_readdat1   <= rdata1;
            ID_EX_readdat2   <= rdata2;
            ID_EX_sign_ext   <= sign_ext_c;
            ID_EX_instr_2016 <= rt;
            ID_EX_instr_1511 <= rd;
        end
    end

endmodule

// File: tb/tb_i_decode.sv
// Bench for i_decode: behavioural model checked every cycle, plus directed
// literal expectations and randomized traffic.
module tb_i_decode;

    logic        clk;
    logic        rst;
    logic [31:0] IF_ID_instr;
    logic [31:0] IF_ID_npc;
    logic        ID_flush;
    logic        MEM_WB_regwrite;
    logic [4:0]  MEM_WB_rd;
    logic [31:0] MEM_WB_writedata;
    logic [1:0]  ID_EX_wb;
    logic [2:0]  ID_EX_m;
    logic [3:0]  ID_EX_ex;
    logic [31:0] ID_EX_npc;
    logic [31:0] ID_EX_readdat1;
    logic [31:0] ID_EX_readdat2;
    logic [31:0] ID_EX_sign_ext;
    logic [4:0]  ID_EX_instr_2016;
    logic [4:0]  ID_EX_instr_1511;

    int checks = 0;
    int errors = 0;

    i_decode dut (
        .clk              (clk),
        .rst              (rst),
        .IF_ID_instr      (IF_ID_instr),
        .IF_ID_npc        (IF_ID_npc),
        .ID_flush         (ID_flush),
        .MEM_WB_regwrite  (MEM_WB_regwrite),
        .MEM_WB_rd        (MEM_WB_rd),
        .MEM_WB_writedata (MEM_WB_writedata),
        .ID_EX_wb         (ID_EX_wb),
        .ID_EX_m          (ID_EX_m),
        .ID_EX_ex         (ID_EX_ex),
        .ID_EX_npc        (ID_EX_npc),
        .ID_EX_readdat1   (ID_EX_readdat1),
        .ID_EX_readdat2   (ID_EX_readdat2),
        .ID_EX_sign_ext   (ID_EX_sign_ext),
        .ID_EX_instr_2016 (ID_EX_instr_2016),
        .ID_EX_instr_1511 (ID_EX_instr_1511)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] mregs [32];
    logic        exp_valid = 1'b0;
    logic [1:0]  e_wb;
    logic [2:0]  e_m;
    logic [3:0]  e_ex;
    logic [31:0] e_npc, e_r1, e_r2, e_sx;
    logic [4:0]  e_2016, e_1511;

    function automatic logic [8:0] ref_ctrl(input logic [5:0] op);
        // returns {ex, m, wb}
        case (op)
            6'h00:   return {4'b1100, 3'b000, 2'b10};
            6'h23:   return {4'b0001, 3'b010, 2'b11};
            6'h2B:   return {4'b0001, 3'b001, 2'b00};
            6'h04:   return {4'b0010, 3'b100, 2'b00};
            default: return 9'd0;
        endcase
    endfunction

    function automatic logic [31:0] ref_read(input logic [4:0] idx);
        if (idx == 5'd0) return 32'd0;
        if (MEM_WB_regwrite && MEM_WB_rd == idx) return MEM_WB_writedata;
        return mregs[idx];
    endfunction

    always @(posedge clk) begin
        logic [8:0] c;
        if (rst) begin
            {e_wb, e_m, e_ex} = '0;
            e_npc = 0; e_r1 = 0; e_r2 = 0; e_sx = 0; e_2016 = 0; e_1511 = 0;
            for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
        end else begin
            c = ID_flush ? 9'd0 : ref_ctrl(IF_ID_instr[31:26]);
            {e_ex, e_m, e_wb} = c;
            e_npc  = IF_ID_npc;
            e_r1   = ref_read(IF_ID_instr[25:21]);
            e_r2   = ref_read(IF_ID_instr[20:16]);
            e_sx   = 32'(signed'(IF_ID_instr[15:0]));
            e_2016 = IF_ID_instr[20:16];
            e_1511 = IF_ID_instr[15:11];
            if (MEM_WB_regwrite && MEM_WB_rd != 5'd0) mregs[MEM_WB_rd] = MEM_WB_writedata;
        end
        exp_valid = 1'b1;
    end

    // Compare process: outputs sampled mid-cycle against the model
    always @(negedge clk) begin
        if (exp_valid) begin
            chk("wb",        32'(ID_EX_wb),         32'(e_wb));
            chk("m",         32'(ID_EX_m),          32'(e_m));
            chk("ex",        32'(ID_EX_ex),         32'(e_ex));
            chk("npc",       ID_EX_npc,             e_npc);
            chk("readdat1",  ID_EX_readdat1,        e_r1);
            chk("readdat2",  ID_EX_readdat2,        e_r2);
            chk("sign_ext",  ID_EX_sign_ext,        e_sx);
            chk("instr2016", 32'(ID_EX_instr_2016), 32'(e_2016));
            chk("instr1511", 32'(ID_EX_instr_1511), 32'(e_1511));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic r, input logic [31:0] ins, input logic [31:0] npc,
                        input logic fl, input logic we, input logic [4:0] wrd,
                        input logic [31:0] wd);
        rst = r; IF_ID_instr = ins; IF_ID_npc = npc; ID_flush = fl;
        MEM_WB_regwrite = we; MEM_WB_rd = wrd; MEM_WB_writedata = wd;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ctrl(input string name, input logic [3:0] ex, input logic [2:0] m,
                            input logic [1:0] wb);
        chk({name, "_ex"}, 32'(ID_EX_ex), 32'(ex));
        chk({name, "_m"},  32'(ID_EX_m),  32'(m));
        chk({name, "_wb"}, 32'(ID_EX_wb), 32'(wb));
    endtask

    initial begin
        rst = 1'b1; IF_ID_instr = 0; IF_ID_npc = 0; ID_flush = 0;
        MEM_WB_regwrite = 0; MEM_WB_rd = 0; MEM_WB_writedata = 0;

        // Reset with random inputs
        repeat (2) step(1'b1, $urandom, $urandom, 1'($urandom), 1'b1, 5'($urandom), $urandom);
        chk_ctrl("rst", 4'b0, 3'b0, 2'b0);
        chk("rst_npc", ID_EX_npc, 32'd0);
        chk("rst_rd1", ID_EX_readdat1, 32'd0);
        chk("rst_sx", ID_EX_sign_ext, 32'd0);

        // Read $5 after reset: add $0,$5,$0
        step(1'b0, 32'h00A00020, 32'h4, 1'b0, 1'b0, 5'd0, 32'd0);
        chk("r5_after_rst", ID_EX_readdat1, 32'd0);

        // Preload $1=7, $2=9, then add $3,$1,$2
        step(1'b0, 32'hFC000000, 32'h8,  1'b0, 1'b1, 5'd1, 32'd7);
        step(1'b0, 32'hFC000000, 32'hC,  1'b0, 1'b1, 5'd2, 32'd9);
        step(1'b0, 32'h00221820, 32'h10, 1'b0, 1'b0, 5'd0, 32'd0);
        chk_ctrl("add", 4'b1100, 3'b000, 2'b10);
        chk("add_rd1", ID_EX_readdat1, 32'd7);
        chk("add_rd2", ID_EX_readdat2, 32'd9);
        chk("add_1511", 32'(ID_EX_instr_1511), 32'd3);
        chk("add_2016", 32'(ID_EX_instr_2016), 32'd2);

        // lw / sw
        step(1'b0, 32'h8C24FFFC, 32'h14, 1'b0, 1'b0, 5'd0, 32'd0);
        chk_ctrl("lw", 4'b0001, 3'b010, 2'b11);
        chk("lw_sx", ID_EX_sign_ext, 32'hFFFFFFFC);
        step(1'b0, 32'hAC240010, 32'h18, 1'b0, 1'b0, 5'd0, 32'd0);
        chk_ctrl("sw", 4'b0001, 3'b001, 2'b00);
        chk("sw_sx", ID_EX_sign_ext, 32'h00000010);

        // Bypass on $1, and a discarded write to $0
        step(1'b0, 32'h00221820, 32'h1C, 1'b0, 1'b1, 5'd1, 32'hDEADBEEF);
        chk("bypass_rd1", ID_EX_readdat1, 32'hDEADBEEF);
        step(1'b0, 32'h00000000, 32'h20, 1'b0, 1'b1, 5'd0, 32'h1234);
        chk("w0_same", ID_EX_readdat1, 32'd0);
        step(1'b0, 32'h00000000, 32'h24, 1'b0, 1'b0, 5'd0, 32'd0);
        chk("w0_later", ID_EX_readdat2, 32'd0);

        // Flushed beq, then undefined opcode
        step(1'b0, 32'h10220003, 32'h28, 1'b1, 1'b0, 5'd0, 32'd0);
        chk_ctrl("flush", 4'b0, 3'b0, 2'b0);
        chk("flush_npc", ID_EX_npc, 32'h28);
        step(1'b0, 32'h10220003, 32'h2C, 1'b0, 1'b0, 5'd0, 32'd0);
        chk_ctrl("beq", 4'b0010, 3'b100, 2'b00);
        step(1'b0, 32'hFC000000, 32'h30, 1'b0, 1'b0, 5'd0, 32'd0);
        chk_ctrl("undef", 4'b0, 3'b0, 2'b0);

        // Reset mid-stream, then re-present the R-type
        step(1'b1, 32'h00221820, 32'h34, 1'b0, 1'b0, 5'd0, 32'd0);
        chk_ctrl("midrst", 4'b0, 3'b0, 2'b0);
        chk("midrst_npc", ID_EX_npc, 32'd0);
        step(1'b0, 32'h00221820, 32'h34, 1'b0, 1'b0, 5'd0, 32'd0);
        chk_ctrl("after_rst", 4'b1100, 3'b000, 2'b10);
        chk("after_rst_npc", ID_EX_npc, 32'h34);
        chk("after_rst_1511", 32'(ID_EX_instr_1511), 32'd3);
        chk("after_rst_rd1", ID_EX_readdat1, 32'd0);

        // Randomized traffic; small register indices to exercise bypass
        for (int n = 0; n < 3000; n++) begin
            logic [5:0]  op;
            logic [31:0] ins;
            case ($urandom_range(0, 5))
                0: op = 6'h00;
                1: op = 6'h23;
                2: op = 6'h2B;
                3: op = 6'h04;
                default: op = 6'($urandom);
            endcase
            ins = $urandom;
            ins[31:26] = op;
            if ($urandom_range(0, 1) == 0) begin
                ins[25:21] = 5'($urandom_range(0, 7));
                ins[20:16] = 5'($urandom_range(0, 7));
            end
            step(($urandom_range(0, 99) < 2), ins, $urandom, ($urandom_range(0, 9) == 0),
                 1'($urandom), 5'($urandom_range(0, 7)), $urandom);
        end

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/i_decode.md
# i_decode

Instruction-decode stage of the 5-stage MIPS pipeline, directly downstream of instruction fetch. Consumes the IF/ID latch outputs, decodes the opcode into control fields, reads two operands from a 32x32 register file (written back by the WB stage), sign-extends the immediate, and registers everything into the ID/EX latch feeding the execute stage.

## Interface
- None: all widths fixed. 32-bit data, 32 registers, 5-bit register indices.

Ports (clock and reset first):
- clk  in  1  single clock; all state updates on its rising edge
- rst  in  1  synchronous, active-high reset
- IF_ID_instr  in  32  instruction from the IF/ID latch
- IF_ID_npc  in  32  PC+4 from the IF/ID latch
- ID_flush  in  1  converts the instruction being latched into a bubble
- MEM_WB_regwrite  in  1  writeback enable
- MEM_WB_rd  in  5  writeback register index
- MEM_WB_writedata  in  32  writeback data
- ID_EX_wb  out  2  {RegWrite, MemtoReg}
- ID_EX_m  out  3  {Branch, MemRead, MemWrite}
- ID_EX_ex  out  4  {RegDst, ALUOp[1:0], ALUSrc}
- ID_EX_npc  out  32  registered IF_ID_npc
- ID_EX_readdat1  out  32  register value at rs (instr[25:21])
- ID_EX_readdat2  out  32  register value at rt (instr[20:16])
- ID_EX_sign_ext  out  32  sign-extended instr[15:0]
- ID_EX_instr_2016  out  5  instr[20:16]
- ID_EX_instr_1511  out  5  instr[15:11]

## Operation
- Control decode on opcode instr[31:26], giving ex/m/wb:
  - 0x00 (R-type): 1100 / 000 / 10
  - 0x23 (lw): 0001 / 010 / 11
  - 0x2B (sw): 0001 / 001 / 00
  - 0x04 (beq): 0010 / 100 / 00
  - any other opcode: all zero (bubble)
- Register file: 32 x 32-bit. Reads are combinational.
- Register write occurs on the rising edge when MEM_WB_regwrite=1 and MEM_WB_rd != 0.
- Register $0 always reads 0. Writes to $0 are discarded.
- Write-through bypass: a read whose index equals MEM_WB_rd in a cycle where a write is qualified returns MEM_WB_writedata, not the stale value.
- Sign extension: {{16{instr[15]}}, instr[15:0]}.
- ID_flush=1: ID_EX_wb, ID_EX_m and ID_EX_ex are latched as zero. Data fields still latch normally. Register-file writes are unaffected.
- Control hazards, stalls and forwarding are handled outside this block.

## Timing
- Latency: IF/ID inputs appear on the ID_EX_* outputs 1 cycle later (rising edge). There is no stall; the block latches every cycle.
- Writeback: data is visible to a same-cycle read via bypass, and stored at the next edge.
- Reset (rst=1 at an edge):
  - every ID_EX_* output is cleared to 0.
  - all 32 registers are cleared to 0.
  - a write pending in the same cycle is discarded.
- Reset asserted mid-stream discards the instruction in flight. The first instruction after deassertion appears 1 cycle after it is presented.
- Priority: rst > ID_flush > normal latch.

## Structure
- Shared package `mips_pkg`:
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ.
  - ex/m/wb field widths and the bubble constant.
- Sub-module `regfile`: storage, $0 hardwiring and write-through bypass.
- Control decode, sign extension and the ID/EX latch stay in the top module.

## Test plan
- Reset: assert rst for 2 cycles with random inputs -> all outputs 0. After deassert, reading $5 returns 0.
- R-type `add $3,$1,$2` (0x00221820), with $1=7 and $2=9 preloaded via writeback -> next cycle:
  - ex=1100, m=000, wb=10
  - readdat1=7, readdat2=9
  - instr_1511=3, instr_2016=2
- lw `lw $4,-4($1)` (0x8C24FFFC) -> ex=0001, m=010, wb=11, sign_ext=0xFFFFFFFC. sw 0xAC240010 -> ex=0001, m=001, wb=00, sign_ext=0x00000010.
- Bypass: write $1=0xDEADBEEF in the same cycle an instruction reads rs=$1 -> readdat1=0xDEADBEEF. A write of 0x1234 to $0 -> a later read of $0 returns 0.
- Flush/bubble:
  - beq 0x10220003 with ID_flush=1 -> ex/m/wb all 0, npc latched.
  - undefined opcode 0x3F -> ex/m/wb all 0.
- Reset mid-stream: assert rst while an R-type is in IF/ID -> outputs 0 next cycle. After deassert, re-presenting it -> correct fields 1 cycle later.
